// File: rtl/run_controller.sv
// Test-harness run controller: holds the core in reset, then runs it until a
// tohost store, a jump-to-self halt or a cycle budget expires.
// Optional retire counter is enabled by defining RUN_CONTROLLER_INSTRET_EN.
module run_controller #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     RESET_CYCLES = 4,
  parameter int unsigned     MAX_CYCLES   = 800,
  parameter int unsigned     HALT_REPEAT  = 3,
  parameter logic [XLEN-1:0] TOHOST_ADDR  = XLEN'(32'h0000_0FF0)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  input  logic            mem_write,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_wdata,
  output logic            core_reset,
  output logic            running,
  output logic            done,
  output logic            pass,
  output logic            timeout,
  output logic [31:0]     cycle_count
`ifdef RUN_CONTROLLER_INSTRET_EN
  ,
  input  logic            retire,
  output logic [31:0]     instret_count
`endif
);

  typedef enum logic [1:0] {HOLD, RUN, DONE, TIMEOUT} state_t;

  state_t          state;
  logic [7:0]      hold_cnt;
  logic [7:0]      rep_cnt;
  logic [7:0]      rep_next;
  logic [XLEN-1:0] prev_pc;
  logic            prev_valid;
  logic [31:0]     cnt_next;
  logic            tohost_hit;
  logic            halt_hit;
  logic            limit_hit;

  // Every RUN edge counts, including the one that leaves RUN, so the frozen
  // count reflects the cycle in which the terminating event was seen.
  always_comb begin
    tohost_hit = mem_write && (mem_addr == TOHOST_ADDR);
    rep_next   = (prev_valid && (pc == prev_pc)) ? rep_cnt + 8'd1 : '0;
    halt_hit   = (rep_next == 8'(HALT_REPEAT));
    cnt_next   = (cycle_count == '1) ? cycle_count : cycle_count + 32'd1;
    limit_hit  = (cnt_next == 32'(MAX_CYCLES));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= HOLD;
      hold_cnt    <= '0;
      rep_cnt     <= '0;
      prev_pc     <= '0;
      prev_valid  <= 1'b0;
      core_reset  <= 1'b1;
      running     <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        HOLD: begin
          if (hold_cnt == 8'(RESET_CYCLES - 1)) begin
            state      <= RUN;
            core_reset <= 1'b0;
            running    <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        RUN: begin
          cycle_count <= cnt_next;
          prev_pc     <= pc;
          prev_valid  <= 1'b1;
          rep_cnt     <= rep_next;
          if (tohost_hit) begin
            state      <= DONE;
            done       <= 1'b1;
            pass       <= (mem_wdata == XLEN'(1));
            core_reset <= 1'b1;
            running    <= 1'b0;
          end else if (halt_hit) begin
            state      <= DONE;
            done       <= 1'b1;
            pass       <= 1'b0;
            core_reset <= 1'b1;
            running    <= 1'b0;
          end else if (limit_hit) begin
            state      <= TIMEOUT;
            timeout    <= 1'b1;
            pass       <= 1'b0;
            core_reset <= 1'b1;
            running    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RUN_CONTROLLER_INSTRET_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instret_count <= '0;
    end else if (state == RUN && retire && instret_count != '1) begin
      instret_count <= instret_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller (default parameters): vector table for the
// basic run, plus hand sequences for tohost, halt, timeout, priority and reset.
module tb_run_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_reset, running, done, pass, timeout;
  logic [31:0] cycle_count;

  int checks   = 0;
  int failures = 0;
  logic [31:0] pcv = 32'h0000_1000;

  run_controller #(
    .XLEN(32),
    .RESET_CYCLES(4),
    .MAX_CYCLES(800),
    .HALT_REPEAT(3),
    .TOHOST_ADDR(32'h0000_0FF0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pc(pc),
    .mem_write(mem_write),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .core_reset(core_reset),
    .running(running),
    .done(done),
    .pass(pass),
    .timeout(timeout),
    .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  // flags order: {core_reset, running, done, pass, timeout}
  typedef struct {
    logic [31:0] pc;
    logic        mw;
    logic [31:0] ma;
    logic [31:0] wd;
    logic [4:0]  flags;
    logic [31:0] cc;
  } vec_t;

  vec_t tbl[15];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [4:0] eflags, input logic [31:0] ecc);
    logic [4:0] aflags;
    aflags = {core_reset, running, done, pass, timeout};
    checks++;
    if (aflags !== eflags || cycle_count !== ecc) begin
      failures++;
      $display("FAIL %s: got cr/run/done/pass/to=%b cc=%0d, want %b cc=%0d",
               nm, aflags, cycle_count, eflags, ecc);
    end
  endtask

  task automatic idle_inputs();
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
  endtask

  // Leaves reset deasserted one tick after an edge, still in HOLD.
  task automatic do_reset();
    idle_inputs();
    pc    = '0;
    reset = 1'b1;
    repeat (10) step();
    chk("reset_state", 5'b10000, 32'd0);
    reset = 1'b0;
  endtask

  task automatic start_run();
    do_reset();
    repeat (4) step();
    chk("run_entry", 5'b01000, 32'd0);
  endtask

  task automatic run_until(input logic [31:0] n);
    int budget = 2000;
    while (cycle_count != n && budget > 0) begin
      pcv = pcv + 32'd4;
      pc  = pcv;
      step();
      budget--;
    end
    if (budget == 0) begin
      checks++;
      failures++;
      $display("FAIL run_until: cc=%0d never reached %0d", cycle_count, n);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    pc = '0;

    tbl[0]  = '{32'h00, 1'b0, 32'h000, 32'd0, 5'b10000, 32'd0};
    tbl[1]  = '{32'h00, 1'b0, 32'h000, 32'd0, 5'b10000, 32'd0};
    tbl[2]  = '{32'h00, 1'b0, 32'h000, 32'd0, 5'b10000, 32'd0};
    tbl[3]  = '{32'h00, 1'b0, 32'h000, 32'd0, 5'b01000, 32'd0};
    tbl[4]  = '{32'h00, 1'b0, 32'h000, 32'd0, 5'b01000, 32'd1};
    tbl[5]  = '{32'h00, 1'b0, 32'h000, 32'd0, 5'b01000, 32'd2};
    tbl[6]  = '{32'h00, 1'b0, 32'h000, 32'd0, 5'b01000, 32'd3};
    tbl[7]  = '{32'h04, 1'b0, 32'h000, 32'd0, 5'b01000, 32'd4};
    tbl[8]  = '{32'h08, 1'b0, 32'h000, 32'd0, 5'b01000, 32'd5};
    tbl[9]  = '{32'h08, 1'b0, 32'h000, 32'd0, 5'b01000, 32'd6};
    tbl[10] = '{32'h0C, 1'b0, 32'h000, 32'd0, 5'b01000, 32'd7};
    tbl[11] = '{32'h10, 1'b1, 32'hFF4, 32'd1, 5'b01000, 32'd8};
    tbl[12] = '{32'h14, 1'b1, 32'hFF0, 32'd3, 5'b10100, 32'd9};
    tbl[13] = '{32'h18, 1'b1, 32'hFF0, 32'd1, 5'b10100, 32'd9};
    tbl[14] = '{32'h1C, 1'b0, 32'h000, 32'd0, 5'b10100, 32'd9};

    // Basic run: hold length, first-cycle repeat exclusion, non-tohost store,
    // failing tohost store and stickiness.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      pc        = tbl[i].pc;
      mem_write = tbl[i].mw;
      mem_addr  = tbl[i].ma;
      mem_wdata = tbl[i].wd;
      step();
      chk($sformatf("vec%0d", i), tbl[i].flags, tbl[i].cc);
    end
    idle_inputs();

    // Passing tohost store at run cycle 50.
    start_run();
    run_until(32'd50);
    mem_write = 1'b1; mem_addr = 32'hFF0; mem_wdata = 32'd1;
    step();
    chk("tohost_pass", 5'b10110, 32'd51);
    idle_inputs();
    repeat (3) step();
    chk("tohost_frozen", 5'b10110, 32'd51);

    // Jump-to-self from run cycle 20.
    start_run();
    run_until(32'd20);
    pc = 32'h40;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("halt_wait%0d", i), 5'b01000, 32'd21 + 32'(i));
    end
    step();
    chk("halt_done", 5'b10100, 32'd24);

    // Toggling pc never halts.
    start_run();
    for (int i = 0; i < 100; i++) begin
      pc = (i % 2 == 0) ? 32'h40 : 32'h44;
      step();
    end
    chk("toggle_running", 5'b01000, 32'd100);

    // Timeout at 800.
    start_run();
    run_until(32'd799);
    pcv = pcv + 32'd4; pc = pcv;
    step();
    chk("timeout", 5'b10001, 32'd800);
    repeat (2) step();
    chk("timeout_frozen", 5'b10001, 32'd800);

    // Store, halt and timeout on one edge: store wins.
    start_run();
    run_until(32'd796);
    pc = 32'hABC0;
    repeat (3) step();
    chk("prio_pre", 5'b01000, 32'd799);
    mem_write = 1'b1; mem_addr = 32'hFF0; mem_wdata = 32'd1;
    step();
    chk("prio_store", 5'b10110, 32'd800);
    idle_inputs();

    // Halt and timeout on one edge: halt wins.
    start_run();
    run_until(32'd796);
    pc = 32'hABC0;
    repeat (4) step();
    chk("prio_halt", 5'b10100, 32'd800);

    // Asynchronous reset mid-run, then full HOLD replay.
    start_run();
    run_until(32'd100);
    #3 reset = 1'b1;
    #1 chk("async_reset", 5'b10000, 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rehold%0d", i), 5'b10000, 32'd0);
    end
    step();
    chk("rerun_entry", 5'b01000, 32'd0);
    pcv = pcv + 32'd4; pc = pcv;
    step();
    chk("rerun_cc1", 5'b01000, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 SHALL have parameter XLEN, default 32, width of pc, mem_addr and mem_wdata.
REQ-002 SHALL have parameter RESET_CYCLES, default 4, clocks core_reset is held after reset deasserts (range 1..255).
REQ-003 SHALL have parameter MAX_CYCLES, default 800, run-cycle budget before timeout (range 2..2^32-1).
REQ-004 SHALL have parameter HALT_REPEAT, default 3, consecutive unchanged-pc cycles that mean jump-to-self halt (range 1..255).
REQ-005 SHALL have parameter TOHOST_ADDR, default 32'h0000_0FF0, store address that ends the run.
REQ-006 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port pc, input, XLEN, core program counter sampled each cycle.
REQ-009 SHALL have ports mem_write, input, 1, and mem_addr and mem_wdata, input, XLEN each: the core data-store strobe, address and data.
REQ-010 SHALL have port core_reset, output, 1, reset driven to the processor.
REQ-011 SHALL have ports running, done, pass and timeout, output, 1 each: run status flags.
REQ-012 SHALL have port cycle_count, output, 32, clocks spent in RUN.

Function
REQ-013 SHALL implement states HOLD, RUN, DONE and TIMEOUT; all outputs are registered.
REQ-014 HOLD SHALL keep core_reset=1 and advance to RUN after exactly RESET_CYCLES rising edges following reset deassertion.
REQ-015 RUN SHALL drive core_reset=0 and running=1 and increment cycle_count by 1 per clock.
REQ-016 In RUN, mem_write=1 with mem_addr==TOHOST_ADDR SHALL go to DONE next edge with pass=1 iff mem_wdata==1, else pass=0.
REQ-017 In RUN, a repeat counter SHALL increment when pc equals the previous cycle's pc and clear otherwise; on reaching HALT_REPEAT it SHALL go to DONE with pass=0.
REQ-018 In RUN, when cycle_count reaches MAX_CYCLES with no other event, it SHALL go to TIMEOUT with timeout=1, pass=0.
REQ-019 Same-cycle events SHALL resolve with priority tohost store > halt repeat > timeout.
REQ-020 The first RUN cycle SHALL NOT count as a pc repeat (previous-pc register invalid until one RUN cycle sampled).
REQ-021 DONE and TIMEOUT SHALL be sticky until reset, reassert core_reset=1, clear running and freeze cycle_count.
REQ-022 done SHALL be 1 only in DONE; timeout SHALL be 1 only in TIMEOUT; done and timeout are never both 1.
REQ-023 cycle_count SHALL saturate at 2^32-1 and never wrap.

Reset
REQ-024 reset=1 SHALL immediately, regardless of clock, force HOLD, core_reset=1, running=0, done=0, pass=0, timeout=0, cycle_count=0, repeat counter and hold counter 0.
REQ-025 reset asserted mid-run or in a terminal state SHALL abort the run and restart the full HOLD sequence after deassertion.

Configuration
REQ-026 With macro RUN_CONTROLLER_INSTRET_EN defined, SHALL add input retire (1) and output instret_count (32) counting retire=1 cycles in RUN, reset to 0, frozen in terminal states, saturating.
REQ-027 Without RUN_CONTROLLER_INSTRET_EN, those ports and the counter SHALL not exist; all other behaviour identical.

Verification
REQ-028 reset high 10 cycles then low, defaults -> core_reset falls after exactly 4 edges; running=1; cycle_count 0 then 1,2,3.
REQ-029 Store mem_addr=0xFF0, mem_wdata=1 at run cycle 50 -> done=1, pass=1, core_reset=1, cycle_count frozen at 51.
REQ-030 Store to 0xFF0 with mem_wdata=3 -> done=1, pass=0; store to 0xFF4 -> no effect, still running.
REQ-031 pc held at 0x40 from run cycle 20 -> done=1, pass=0 after 3 repeat cycles; pc toggling 0x40/0x44 never halts.
REQ-032 pc always changing, no tohost store -> timeout=1, done=0 when cycle_count=800; tohost store on that same cycle -> done=1, timeout=0.
REQ-033 reset pulsed mid-run at cycle 100 -> all outputs cleared asynchronously; HOLD reruns for 4 cycles; cycle_count restarts at 0.
